seg7_scan_mux: RTL
==================

Name: seg7_scan_mux

Overview:
Downstream display stage for the digit counter. It takes a bus of packed BCD digits from the counter logic and time-multiplexes them onto one shared 7-segment bus with one-hot digit enables. Features: non-overlap blanking between digits, leading-zero suppression, and tear-free updates (new values take effect only at frame boundaries). Segment decode reuses the existing seg7 decoder.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8).
REFRESH_COUNT, 24'd10_000, cycles each digit is enabled (1 ms at 10 MHz); must be >= 1.
BLANK_CYCLES, 8'd16, dead cycles between digits (anti-ghosting); must be >= 1.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
load  input  1  single-cycle strobe; capture digits_in and dp_in.
digits_in  input  4*NUM_DIGITS  packed BCD digits; [3:0] is digit 0 (least significant).
dp_in  input  NUM_DIGITS  decimal point per digit.
blank_lz  input  1  1 = suppress leading zeros.
segments  output  7  segment drive, same bit order as seg7; active-high.
dp  output  1  decimal point for the active digit.
digit_en  output  NUM_DIGITS  one-hot digit enable, active-high; all zero while blanking.
load_ack  output  1  one-cycle pulse, the cycle after a captured load.
frame_start  output  1  one-cycle pulse when the display register is updated.

Behaviour:
- One clock domain (clk); reset is asynchronous, active-high.
- Reset values: segments = 0, dp = 0, digit_en = 0, load_ack = 0, frame_start = 0. Internal state also resets: index = 0, state = BLANK, timer = 0, shadow = 0, display = 0, pending = 0.
- Reset asserted mid-operation forces all outputs to 0 immediately, with no waiting for a clock edge.
- Load path:
  - When load = 1, digits_in and dp_in are written to the shadow register and pending is set.
  - load_ack pulses on the following cycle.
  - Back-to-back loads are legal; the last one wins.
- FSM, states BLANK and SHOW:
  - BLANK: digit_en = 0, segments = 0, dp = 0. Lasts exactly BLANK_CYCLES cycles (timer 0..BLANK_CYCLES-1), then goes to SHOW with timer = 0.
  - SHOW: digit_en = one-hot(index). Lasts exactly REFRESH_COUNT cycles, then goes to BLANK and index advances modulo NUM_DIGITS.
- Frame boundary:
  - Defined as the SHOW->BLANK transition where index wraps from NUM_DIGITS-1 to 0.
  - If pending = 1 at the boundary, shadow is copied to display, pending is cleared and frame_start pulses on that same edge.
  - If load coincides with the boundary, display takes the pre-load shadow contents and pending remains set. The new value is shown one frame later.
- Frame period = NUM_DIGITS*(REFRESH_COUNT+BLANK_CYCLES) cycles. After reset release the first cycle is BLANK with index 0.
- Output timing: outputs are combinational decode of registered state and the display register only. There is no combinational path from any input to any output.
- Digit decode in SHOW:
  - segments = seg7(display nibble[index]).
  - A nibble > 9 forces segments = 0; dp is unaffected by this rule.
  - dp = display dp[index].
- Leading-zero blanking (blank_lz = 1, sampled live):
  - Digit i is blanked if i > 0 and every display nibble from i up to NUM_DIGITS-1 equals 0.
  - Digit 0 is never blanked.
  - A blanked digit keeps digit_en asserted with segments = 0; dp still shows.
- Timer width is 24 bits; there is no wrap issue within the legal parameter range.

Decomposition:
- Shared package holds:
  - state enum {BLANK, SHOW};
  - BCD_INVALID threshold (4'd9);
  - default REFRESH_COUNT / BLANK_CYCLES constants for the 10 MHz board clock.
- One sub-module: the existing seg7 decoder, instantiated once on the muxed nibble. There is no per-digit decoder.

Test Plan:
All scenarios use NUM_DIGITS = 4, REFRESH_COUNT = 4, BLANK_CYCLES = 2; frame = 24 cycles.
1. Release reset, no load -> 2 cycles all-zero outputs, then digit_en = 0001 for 4 cycles with segments = seg7(0). The 0010, 0100, 1000 phases follow, each preceded by 2 blank cycles; the cycle repeats every 24 cycles.
2. load with digits_in = 16'h1234 mid-frame -> load_ack the next cycle; old zeros persist until the wrap; frame_start pulses; then digit 0 shows 4, digit 1 shows 3, digit 2 shows 2, digit 3 shows 1.
3. blank_lz = 1, digits 16'h0050 -> digits 3 and 2 show segments = 0 with enables asserted; digit 1 shows 5, digit 0 shows 0. With 16'h0000 only digit 0 shows 0.
4. Nibble 4'hC at digit 2 with dp_in[2] = 1 -> segments = 0 and dp = 1 during digit_en = 0100.
5. load of 16'h9999 exactly on the boundary cycle -> the prior shadow value is shown for the next frame; 9999 appears after the following boundary, with a second frame_start pulse.
6. reset asserted 2 cycles into the SHOW of digit 2 -> all outputs 0 immediately. After release: BLANK, then index 0, with display = 0 and pending = 0.

Source files
------------

// File: rtl/seg7_scan_mux_pkg.sv
`default_nettype none
// ============================================================================
// seg7_scan_mux_pkg -- shared types and constants for the scanned 7-seg mux
// Rev 1.0
// ============================================================================
package seg7_scan_mux_pkg;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  // Largest nibble value that decodes to a glyph; anything above is dark.
  localparam logic [3:0]  BCD_INVALID       = 4'd9;

  // 1 ms per digit and 1.6 us dead time at the 10 MHz board clock.
  localparam logic [23:0] DEF_REFRESH_COUNT = 24'd10_000;
  localparam logic [7:0]  DEF_BLANK_CYCLES  = 8'd16;

endpackage
`default_nettype wire

// File: rtl/seg7_scan_mux_if.sv
`default_nettype none
// ============================================================================
// seg7_scan_mux_if -- digit-load and display-drive signals of the scan mux
// Rev 1.0
// ============================================================================
interface seg7_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_lz;
  logic [6:0]              segments;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    load_ack;
  logic                    frame_start;

  modport master (
    output load, digits_in, dp_in, blank_lz,
    input  segments, dp, digit_en, load_ack, frame_start
  );

  modport slave (
    input  load, digits_in, dp_in, blank_lz,
    output segments, dp, digit_en, load_ack, frame_start
  );

endinterface
`default_nettype wire

// File: rtl/seg7_scan_mux_seg7.sv
`default_nettype none
// ============================================================================
// seg7_scan_mux_seg7 -- BCD to 7-segment decoder, bits {g,f,e,d,c,b,a}
// Rev 1.0
// ============================================================================
module seg7_scan_mux_seg7
  import seg7_scan_mux_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] segments
);

  always_comb begin
    segments = 7'h00;
    if (bcd <= BCD_INVALID) begin
      case (bcd)
        4'd0:    segments = 7'h3F;
        4'd1:    segments = 7'h06;
        4'd2:    segments = 7'h5B;
        4'd3:    segments = 7'h4F;
        4'd4:    segments = 7'h66;
        4'd5:    segments = 7'h6D;
        4'd6:    segments = 7'h7D;
        4'd7:    segments = 7'h07;
        4'd8:    segments = 7'h7F;
        4'd9:    segments = 7'h6F;
        default: segments = 7'h00;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_mux.sv
`default_nettype none
// ============================================================================
// seg7_scan_mux -- time-multiplexed 7-seg driver, tear-free frame updates
// Rev 1.0
// ============================================================================
module seg7_scan_mux
  import seg7_scan_mux_pkg::*;
#(
  parameter int          NUM_DIGITS    = 4,
  parameter logic [23:0] REFRESH_COUNT = DEF_REFRESH_COUNT,
  parameter logic [7:0]  BLANK_CYCLES  = DEF_BLANK_CYCLES
) (
  input  logic           clk,
  input  logic           reset,
  seg7_scan_mux_if.slave bus
);

  localparam int               IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [0:0]       ST_BLANK   = BLANK;
  localparam logic [0:0]       ST_SHOW    = SHOW;
  localparam logic [23:0]      BLANK_LAST = {16'd0, BLANK_CYCLES} - 24'd1;
  localparam logic [23:0]      SHOW_LAST  = REFRESH_COUNT - 24'd1;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [0:0]              state;
  logic [23:0]             timer;
  logic [IDX_W-1:0]        index;
  logic [4*NUM_DIGITS-1:0] shadow_digits;
  logic [4*NUM_DIGITS-1:0] display_digits;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   display_dp;
  logic                    pending;
  logic                    load_ack_q;
  logic                    frame_start_q;
  logic                    blank_lz_q;

  logic                    show_last;
  logic                    frame_wrap;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    zeros_above;
  logic [3:0]              nibble;
  logic                    nibble_dp;
  logic [6:0]              seg_raw;
  logic                    seg_on;

  assign show_last  = (state == ST_SHOW) && (timer == SHOW_LAST);
  assign frame_wrap = show_last && (index == IDX_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_BLANK;
      timer <= '0;
      index <= '0;
    end else begin
      case (state)
        ST_BLANK: begin
          if (timer == BLANK_LAST) begin
            state <= ST_SHOW;
            timer <= '0;
          end else begin
            timer <= timer + 24'd1;
          end
        end
        default: begin
          if (show_last) begin
            state <= ST_BLANK;
            timer <= '0;
            index <= (index == IDX_LAST) ? '0 : index + IDX_W'(1);
          end else begin
            timer <= timer + 24'd1;
          end
        end
      endcase
    end
  end

  // The display copy reads the pre-load shadow, so a load landing on the
  // wrap edge is deferred one frame and keeps pending set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_digits  <= '0;
      shadow_dp      <= '0;
      display_digits <= '0;
      display_dp     <= '0;
      pending        <= 1'b0;
      load_ack_q     <= 1'b0;
      frame_start_q  <= 1'b0;
      blank_lz_q     <= 1'b0;
    end else begin
      load_ack_q    <= bus.load;
      blank_lz_q    <= bus.blank_lz;
      frame_start_q <= frame_wrap && pending;
      if (frame_wrap && pending) begin
        display_digits <= shadow_digits;
        display_dp     <= shadow_dp;
      end
      if (bus.load) begin
        shadow_digits <= bus.digits_in;
        shadow_dp     <= bus.dp_in;
        pending       <= 1'b1;
      end else if (frame_wrap) begin
        pending <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit_en
    assign digit_en[g] = (state == ST_SHOW) && (index == IDX_W'(g));
  end

  always_comb begin
    nibble    = '0;
    nibble_dp = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (index == IDX_W'(i)) begin
        nibble    = display_digits[4*i +: 4];
        nibble_dp = display_dp[i];
      end
    end
  end

  // lz_blank[i]: every nibble from i up to the top digit is zero.
  always_comb begin
    lz_blank    = '0;
    zeros_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zeros_above = zeros_above && (display_digits[4*i +: 4] == 4'd0);
      lz_blank[i] = zeros_above;
    end
  end

  seg7_scan_mux_seg7 u_seg7 (
    .bcd      (nibble),
    .segments (seg_raw)
  );

  assign seg_on = (state == ST_SHOW) && (nibble <= BCD_INVALID) &&
                  !(blank_lz_q && |(lz_blank & digit_en));

  assign bus.segments    = seg_on ? seg_raw : 7'h00;
  assign bus.dp          = (state == ST_SHOW) && nibble_dp;
  assign bus.digit_en    = digit_en;
  assign bus.load_ack    = load_ack_q;
  assign bus.frame_start = frame_start_q;

endmodule
`default_nettype wire
